// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: shared state encoding, data widths and error-bit positions
// for the sensor sampling scheduler.
package sensor_sched_pkg;
   localparam int ADC_W   = 24;
   localparam int TEMP_W  = 8;
   localparam int ERR_SPI = 0;
   localparam int ERR_I2C = 1;
   localparam int ERR_OVR = 2;
   typedef enum logic [2:0] {IDLE, SPI_REQ, SPI_WAIT, I2C_REQ, I2C_WAIT, COMMIT} state_e;
endpackage

// File: rtl/sched_timer.sv
// sched_timer: loadable down-counter that parks at zero and flags it.
module sched_timer #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= RST_VAL;
      else cnt_q <= cnt_d;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: periodically reads the accelerometer (SPI) then the temperature
// sensor (I2C), each guarded by a timeout, and publishes both values together.
module sensor_scheduler
   import sensor_sched_pkg::*;
#(
   parameter int SAMPLE_PERIOD  = 10_000_000,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic              enable,
   output logic              spi_start,
   input  logic              spi_done,
   input  logic [ADC_W-1:0]  spi_data,
   output logic              i2c_start,
   input  logic              i2c_done,
   input  logic [TEMP_W-1:0] i2c_data,
   output logic [ADC_W-1:0]  adc_value,
   output logic [TEMP_W-1:0] temp_value,
   output logic              sample_valid,
   output logic [2:0]        err_flags,
   input  logic              err_clear
);
   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_e            state_q;
   logic              pending_q;
   logic [ADC_W-1:0]  adc_sh_q;
   logic [TEMP_W-1:0] temp_sh_q;
   logic              per_zero, to_zero, to_load;
   logic              spi_ok, spi_to, i2c_ok, i2c_to;
   logic [2:0]        err_set;
   assign spi_ok  = state_q == SPI_WAIT && spi_done;
   assign spi_to  = state_q == SPI_WAIT && !spi_done && to_zero;
   assign i2c_ok  = state_q == I2C_WAIT && i2c_done;
   assign i2c_to  = state_q == I2C_WAIT && !i2c_done && to_zero;
   // timeout is armed on entry to each request state, together with its start pulse
   assign to_load = (state_q == IDLE && pending_q) || spi_ok || spi_to;
   always_comb begin
      err_set          = '0;
      err_set[ERR_SPI] = spi_to;
      err_set[ERR_I2C] = i2c_to;
      err_set[ERR_OVR] = per_zero && enable && pending_q;
   end
   sched_timer #(.W(PW), .RST_VAL(PW'(SAMPLE_PERIOD - 1))) u_period (
      .clk(CLK100MHZ), .rst(reset), .load_i(per_zero),
      .load_val_i(PW'(SAMPLE_PERIOD - 1)), .zero_o(per_zero)
   );
   sched_timer #(.W(TW), .RST_VAL('0)) u_timeout (
      .clk(CLK100MHZ), .rst(reset), .load_i(to_load),
      .load_val_i(TW'(TIMEOUT_CYCLES - 1)), .zero_o(to_zero)
   );
   always_ff @(posedge CLK100MHZ or posedge reset)
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= 1'b0;
         adc_sh_q     <= '0;
         temp_sh_q    <= '0;
         adc_value    <= '0;
         temp_value   <= '0;
         sample_valid <= 1'b0;
         spi_start    <= 1'b0;
         i2c_start    <= 1'b0;
         err_flags    <= '0;
      end else begin
         spi_start    <= 1'b0;
         i2c_start    <= 1'b0;
         sample_valid <= 1'b0;
         pending_q    <= (per_zero && enable) || (pending_q && state_q != IDLE);
         err_flags    <= (err_clear ? 3'b000 : err_flags) | err_set;
         case (state_q)
            IDLE: if (pending_q) begin
               state_q   <= SPI_REQ;
               spi_start <= 1'b1;
            end
            SPI_REQ: state_q <= SPI_WAIT;
            SPI_WAIT: if (spi_ok || spi_to) begin
               state_q   <= I2C_REQ;
               i2c_start <= 1'b1;
               if (spi_ok) adc_sh_q <= spi_data;
            end
            I2C_REQ: state_q <= I2C_WAIT;
            I2C_WAIT: if (i2c_ok || i2c_to) begin
               state_q <= COMMIT;
               if (i2c_ok) temp_sh_q <= i2c_data;
            end
            COMMIT: begin
               adc_value    <= adc_sh_q;
               temp_value   <= temp_sh_q;
               sample_valid <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sensor_scheduler.sv
// tb_sensor_scheduler: directed scenarios for sensor_scheduler; a second instance with
// a long timeout lets a read stall past two sample periods to provoke an overrun.
module tb_sensor_scheduler;
   logic        clk = 0, reset = 0, enable = 0, spi_done = 0, i2c_done = 0, err_clear = 0;
   logic [23:0] spi_data = 0;
   logic [7:0]  i2c_data = 0;
   logic        spi_start, i2c_start, sample_valid;
   logic [23:0] adc_value;
   logic [7:0]  temp_value;
   logic [2:0]  err_flags;
   logic        o_spi_start, o_i2c_start, o_sample_valid;
   logic [23:0] o_adc_value;
   logic [7:0]  o_temp_value;
   logic [2:0]  o_err_flags;
   int checks = 0, fails = 0;

   always #5 clk = ~clk;

   sensor_scheduler #(.SAMPLE_PERIOD(100), .TIMEOUT_CYCLES(20)) dut (
      .CLK100MHZ(clk), .reset(reset), .enable(enable), .spi_start(spi_start),
      .spi_done(spi_done), .spi_data(spi_data), .i2c_start(i2c_start),
      .i2c_done(i2c_done), .i2c_data(i2c_data), .adc_value(adc_value),
      .temp_value(temp_value), .sample_valid(sample_valid), .err_flags(err_flags),
      .err_clear(err_clear)
   );
   sensor_scheduler #(.SAMPLE_PERIOD(100), .TIMEOUT_CYCLES(300)) dut_ovr (
      .CLK100MHZ(clk), .reset(reset), .enable(enable), .spi_start(o_spi_start),
      .spi_done(spi_done), .spi_data(spi_data), .i2c_start(o_i2c_start),
      .i2c_done(i2c_done), .i2c_data(i2c_data), .adc_value(o_adc_value),
      .temp_value(o_temp_value), .sample_valid(o_sample_valid), .err_flags(o_err_flags),
      .err_clear(err_clear)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig(input int w);
      case (w)
         0: return spi_start;
         1: return i2c_start;
         2: return sample_valid;
         3: return o_spi_start;
         4: return o_i2c_start;
         default: return o_sample_valid;
      endcase
   endfunction

   task automatic wait_sig(input int w, input int max, output int n);
      n = 0;
      while (!sig(w) && n < max) begin
         tick(1);
         n++;
      end
   endtask

   task automatic pulse_spi(input logic [23:0] d);
      spi_data = d;
      spi_done = 1;
      tick(1);
      spi_done = 0;
   endtask

   task automatic pulse_i2c(input logic [7:0] d);
      i2c_data = d;
      i2c_done = 1;
      tick(1);
      i2c_done = 0;
   endtask

   task automatic test_reset;
      #1 reset = 1;
      #1;
      checks++;
      if ({spi_start, i2c_start, sample_valid} !== 3'b000) begin
         fails++;
         $display("FAIL reset_pulses: got %b expected 000", {spi_start, i2c_start, sample_valid});
      end
      checks++;
      if ({adc_value, temp_value} !== 32'h0) begin
         fails++;
         $display("FAIL reset_values: got %h expected 0", {adc_value, temp_value});
      end
      checks++;
      if (err_flags !== 3'b000) begin
         fails++;
         $display("FAIL reset_err: got %b expected 000", err_flags);
      end
      tick(2);
      reset  = 0;
      enable = 1;
   endtask

   task automatic test_normal;
      int n;
      wait_sig(0, 120, n);
      checks++;
      if (!spi_start || n != 101) begin
         fails++;
         $display("FAIL first_start: got %0d cycles expected 101", n);
      end
      tick(5);
      pulse_spi(24'hA1B2C3);
      checks++;
      if ({i2c_start, spi_start} !== 2'b10) begin
         fails++;
         $display("FAIL normal_i2c_start: got %b expected 10", {i2c_start, spi_start});
      end
      tick(7);
      pulse_i2c(8'h19);
      wait_sig(2, 5, n);
      checks++;
      if (!sample_valid || n != 1) begin
         fails++;
         $display("FAIL normal_valid: got %0d cycles expected 1", n);
      end
      checks++;
      if ({adc_value, temp_value, err_flags} !== {24'hA1B2C3, 8'h19, 3'b000}) begin
         fails++;
         $display("FAIL normal_data: got %h %h %b expected a1b2c3 19 000", adc_value, temp_value, err_flags);
      end
      tick(1);
      checks++;
      if (sample_valid !== 1'b0) begin
         fails++;
         $display("FAIL valid_width: got %b expected 0", sample_valid);
      end
   endtask

   task automatic test_spi_timeout;
      int n;
      tick(3);
      pulse_spi(24'hDEADBE);
      pulse_i2c(8'h77);
      wait_sig(0, 120, n);
      tick(2);
      pulse_i2c(8'h77);
      tick(16);
      checks++;
      if ({err_flags, i2c_start} !== 4'b0000) begin
         fails++;
         $display("FAIL spi_to_early: got %b expected 0000", {err_flags, i2c_start});
      end
      tick(1);
      checks++;
      if ({err_flags, i2c_start} !== 4'b0011) begin
         fails++;
         $display("FAIL spi_to_flag: got %b expected 0011", {err_flags, i2c_start});
      end
      tick(20);
      checks++;
      if (err_flags !== 3'b011) begin
         fails++;
         $display("FAIL i2c_to_flag: got %b expected 011", err_flags);
      end
      tick(1);
      checks++;
      if ({sample_valid, adc_value, temp_value} !== {1'b1, 24'hA1B2C3, 8'h19}) begin
         fails++;
         $display("FAIL to_keep: got %b %h %h expected 1 a1b2c3 19", sample_valid, adc_value, temp_value);
      end
   endtask

   task automatic test_err_clear;
      int n;
      err_clear = 1;
      tick(1);
      err_clear = 0;
      checks++;
      if (err_flags !== 3'b000) begin
         fails++;
         $display("FAIL err_clear: got %b expected 000", err_flags);
      end
      wait_sig(0, 120, n);
      tick(19);
      err_clear = 1;
      tick(1);
      err_clear = 0;
      checks++;
      if (err_flags !== 3'b001) begin
         fails++;
         $display("FAIL clear_vs_set: got %b expected 001", err_flags);
      end
      tick(2);
      pulse_i2c(8'h3C);
      wait_sig(2, 5, n);
      checks++;
      if ({sample_valid, adc_value, temp_value} !== {1'b1, 24'hA1B2C3, 8'h3C}) begin
         fails++;
         $display("FAIL clear_seq: got %b %h %h expected 1 a1b2c3 3c", sample_valid, adc_value, temp_value);
      end
      err_clear = 1;
      tick(1);
      err_clear = 0;
   endtask

   task automatic test_race;
      int n;
      wait_sig(0, 120, n);
      tick(19);
      pulse_spi(24'h5A5A5A);
      checks++;
      if ({i2c_start, err_flags} !== 4'b1000) begin
         fails++;
         $display("FAIL race_flag: got %b expected 1000", {i2c_start, err_flags});
      end
      tick(1);
      pulse_i2c(8'h44);
      wait_sig(2, 5, n);
      checks++;
      if ({sample_valid, adc_value, temp_value, err_flags} !== {1'b1, 24'h5A5A5A, 8'h44, 3'b000}) begin
         fails++;
         $display("FAIL race_data: got %b %h %h %b expected 1 5a5a5a 44 000", sample_valid, adc_value, temp_value, err_flags);
      end
   endtask

   task automatic test_enable_hold;
      int n, starts;
      wait_sig(0, 120, n);
      enable = 0;
      tick(2);
      pulse_spi(24'h010203);
      wait_sig(1, 5, n);
      tick(1);
      pulse_i2c(8'h0F);
      wait_sig(2, 5, n);
      checks++;
      if ({sample_valid, adc_value, temp_value} !== {1'b1, 24'h010203, 8'h0F}) begin
         fails++;
         $display("FAIL hold_complete: got %b %h %h expected 1 010203 0f", sample_valid, adc_value, temp_value);
      end
      starts = 0;
      for (int i = 0; i < 250; i++) begin
         tick(1);
         if (spi_start) starts++;
      end
      checks++;
      if (starts != 0) begin
         fails++;
         $display("FAIL disabled_starts: got %0d expected 0", starts);
      end
      enable = 1;
   endtask

   task automatic test_reset_mid;
      int n;
      logic sv_seen;
      wait_sig(0, 120, n);
      tick(3);
      #2 reset = 1;
      #1;
      checks++;
      if ({adc_value, temp_value, err_flags, sample_valid, spi_start, i2c_start} !== '0) begin
         fails++;
         $display("FAIL mid_reset: got %h %h %b %b%b%b expected all 0", adc_value, temp_value, err_flags, sample_valid, spi_start, i2c_start);
      end
      @(negedge clk);
      reset = 0;
      n = 0;
      sv_seen = 0;
      while (!spi_start && n < 120) begin
         tick(1);
         n++;
         if (sample_valid) sv_seen = 1;
      end
      checks++;
      if (!spi_start || n != 101) begin
         fails++;
         $display("FAIL restart_latency: got %0d cycles expected 101", n);
      end
      checks++;
      if (sv_seen !== 1'b0) begin
         fails++;
         $display("FAIL stale_valid: got %b expected 0", sv_seen);
      end
      tick(2);
      pulse_spi(24'h00BEEF);
      tick(1);
      pulse_i2c(8'h21);
      wait_sig(2, 5, n);
      checks++;
      if ({sample_valid, adc_value, temp_value} !== {1'b1, 24'h00BEEF, 8'h21}) begin
         fails++;
         $display("FAIL post_reset_seq: got %b %h %h expected 1 00beef 21", sample_valid, adc_value, temp_value);
      end
   endtask

   task automatic test_overrun;
      int n, starts;
      reset = 1;
      tick(1);
      reset = 0;
      wait_sig(3, 120, n);
      checks++;
      if (!o_spi_start || n != 101) begin
         fails++;
         $display("FAIL ovr_first_start: got %0d cycles expected 101", n);
      end
      tick(2);
      pulse_spi(24'h123456);
      wait_sig(4, 5, n);
      tick(200);
      checks++;
      if (o_err_flags !== 3'b100) begin
         fails++;
         $display("FAIL overrun_flag: got %b expected 100", o_err_flags);
      end
      pulse_i2c(8'h5A);
      wait_sig(5, 5, n);
      checks++;
      if ({o_sample_valid, o_adc_value, o_temp_value} !== {1'b1, 24'h123456, 8'h5A}) begin
         fails++;
         $display("FAIL ovr_data: got %b %h %h expected 1 123456 5a", o_sample_valid, o_adc_value, o_temp_value);
      end
      wait_sig(3, 5, n);
      checks++;
      if (!o_spi_start || n != 1) begin
         fails++;
         $display("FAIL ovr_immediate: got %0d cycles expected 1", n);
      end
      tick(2);
      pulse_spi(24'h111111);
      wait_sig(4, 5, n);
      tick(1);
      pulse_i2c(8'h22);
      wait_sig(5, 5, n);
      checks++;
      if ({o_sample_valid, o_adc_value, o_temp_value} !== {1'b1, 24'h111111, 8'h22}) begin
         fails++;
         $display("FAIL ovr_second: got %b %h %h expected 1 111111 22", o_sample_valid, o_adc_value, o_temp_value);
      end
      starts = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (o_spi_start) starts++;
      end
      checks++;
      if (starts != 0) begin
         fails++;
         $display("FAIL ovr_extra_start: got %0d expected 0", starts);
      end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_spi_timeout;
      test_err_clear;
      test_race;
      test_enable_hold;
      test_reset_mid;
      test_overrun;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
